// File: rtl/dma_uart_pkg.sv
// Shared types and constants for the DMA-attached UART byte device.
package dma_uart_pkg;
  localparam int DATA_BITS     = 8;
  localparam int SYNC_STAGES   = 2;
  localparam int RTS_THRESHOLD = 2;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} e_rx_state;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} e_tx_state;
endpackage

// File: rtl/dma_uart_device_fifo.sv
// First-word fall-through byte FIFO; head byte reads as zero while empty.
module dma_byte_fifo
  import dma_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 empty,
  output logic                 full,
  output logic [DEPTH_LOG2:0]  free_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0]  wptr, rptr;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic                 do_push, do_pop;

  assign empty      = (wptr == rptr);
  assign full       = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                      (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign do_pop     = pop && !empty;
  // A full FIFO still takes a byte when the same cycle frees a slot.
  assign do_push    = push && (!full || do_pop);
  assign rdata      = empty ? '0 : mem[rptr[DEPTH_LOG2-1:0]];
  assign free_count = (DEPTH_LOG2+1)'(DEPTH) - (wptr - rptr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= wdata;
  end
endmodule

// File: rtl/dma_uart_device.sv
// 8N1 UART device slot for the DMA engine: RX and TX byte FIFOs plus serialisers.
// Optional RTS/CTS hardware flow control is enabled by DMA_UART_HW_FLOW_CTRL_EN.
module dma_uart_device
  import dma_uart_pkg::*;
#(
  parameter int CLK_FREQ        = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 rx_empty,
  input  logic                 rx_read,
  output logic [DATA_BITS-1:0] rx_rdata,
  output logic                 tx_full,
  input  logic                 tx_write,
  input  logic [DATA_BITS-1:0] tx_wdata,
  input  logic                 uart_rxd,
  output logic                 uart_txd,
`ifdef DMA_UART_HW_FLOW_CTRL_EN
  input  logic                 uart_cts_n,
  output logic                 uart_rts_n,
`endif
  input  logic                 clear_errors,
  output logic                 rx_overrun,
  output logic                 rx_framing_error
);
  localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CNT_W      = $clog2(BIT_TICKS + 1);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(BIT_TICKS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_TICKS);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  if (BIT_TICKS < 4) begin : g_bad_baud
    $error("dma_uart_device: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  logic [SYNC_STAGES:0]   rxd_pipe;
  logic                   rxd_s, rxd_fall, cts_ok;
  e_rx_state              rx_state, rx_state_n;
  e_tx_state              tx_state, tx_state_n;
  logic [CNT_W-1:0]       rx_cnt, rx_cnt_n, tx_cnt, tx_cnt_n;
  logic [2:0]             rx_bit, rx_bit_n, tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0]   rx_shreg, rx_shreg_n, tx_shreg, tx_shreg_n, tx_rdata;
  logic                   rx_done, rx_push, rx_full, tx_empty, tx_pop, txd_n;
  logic                   overrun_set, framing_set;
  logic [FIFO_DEPTH_LOG2:0] rx_free;

  assign rxd_s    = rxd_pipe[SYNC_STAGES-1];
  assign rxd_fall = !rxd_s && rxd_pipe[SYNC_STAGES];

`ifdef DMA_UART_HW_FLOW_CTRL_EN
  logic [SYNC_STAGES-1:0] cts_pipe;
  assign cts_ok = !cts_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_pipe   <= '1;
      uart_rts_n <= 1'b1;
    end else begin
      cts_pipe   <= {cts_pipe[SYNC_STAGES-2:0], uart_cts_n};
      uart_rts_n <= (rx_free <= (FIFO_DEPTH_LOG2+1)'(RTS_THRESHOLD));
    end
  end
`else
  assign cts_ok = 1'b1;
`endif

  dma_byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rx_push),
    .wdata      (rx_shreg),
    .pop        (rx_read),
    .rdata      (rx_rdata),
    .empty      (rx_empty),
    .full       (rx_full),
    .free_count (rx_free)
  );

  dma_byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (tx_write),
    .wdata      (tx_wdata),
    .pop        (tx_pop),
    .rdata      (tx_rdata),
    .empty      (tx_empty),
    .full       (tx_full),
    .free_count ()
  );

  // RX: counters expire on the value 1 so a load of N gives exactly N cycles.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt - 1'b1;
    rx_bit_n   = rx_bit;
    rx_shreg_n = rx_shreg;
    rx_done    = 1'b0;
    case (rx_state)
      R_IDLE: begin
        rx_cnt_n = rx_cnt;
        if (rxd_fall) begin
          rx_state_n = R_START;
          rx_cnt_n   = HALF_CNT;
        end
      end
      R_START: if (rx_cnt == CNT_W'(1)) begin
        rx_state_n = rxd_s ? R_IDLE : R_DATA;
        rx_cnt_n   = BIT_CNT;
        rx_bit_n   = '0;
      end
      R_DATA: if (rx_cnt == CNT_W'(1)) begin
        rx_shreg_n = {rxd_s, rx_shreg[DATA_BITS-1:1]};
        rx_cnt_n   = BIT_CNT;
        rx_bit_n   = rx_bit + 1'b1;
        if (rx_bit == LAST_BIT) rx_state_n = R_STOP;
      end
      R_STOP: if (rx_cnt == CNT_W'(1)) begin
        rx_done    = 1'b1;
        rx_state_n = R_IDLE;
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  assign rx_push     = rx_done && rxd_s;
  assign overrun_set = rx_push && rx_full && !rx_read;
  assign framing_set = rx_done && !rxd_s;

  // TX: the stop bit chains straight into the next start bit when a byte waits.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt - 1'b1;
    tx_bit_n   = tx_bit;
    tx_shreg_n = tx_shreg;
    tx_pop     = 1'b0;
    case (tx_state)
      T_IDLE: begin
        tx_cnt_n = tx_cnt;
        if (!tx_empty && cts_ok) begin
          tx_pop     = 1'b1;
          tx_shreg_n = tx_rdata;
          tx_state_n = T_START;
          tx_cnt_n   = BIT_CNT;
        end
      end
      T_START: if (tx_cnt == CNT_W'(1)) begin
        tx_state_n = T_DATA;
        tx_cnt_n   = BIT_CNT;
        tx_bit_n   = '0;
      end
      T_DATA: if (tx_cnt == CNT_W'(1)) begin
        tx_cnt_n = BIT_CNT;
        if (tx_bit == LAST_BIT) begin
          tx_state_n = T_STOP;
        end else begin
          tx_shreg_n = tx_shreg >> 1;
          tx_bit_n   = tx_bit + 1'b1;
        end
      end
      T_STOP: if (tx_cnt == CNT_W'(1)) begin
        tx_cnt_n = BIT_CNT;
        if (!tx_empty && cts_ok) begin
          tx_pop     = 1'b1;
          tx_shreg_n = tx_rdata;
          tx_state_n = T_START;
        end else begin
          tx_state_n = T_IDLE;
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
    case (tx_state_n)
      T_START: txd_n = 1'b0;
      T_DATA:  txd_n = tx_shreg_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_pipe         <= '1;
      rx_state         <= R_IDLE;
      rx_cnt           <= '0;
      rx_bit           <= '0;
      tx_state         <= T_IDLE;
      tx_cnt           <= '0;
      tx_bit           <= '0;
      uart_txd         <= 1'b1;
      rx_overrun       <= 1'b0;
      rx_framing_error <= 1'b0;
    end else begin
      rxd_pipe <= {rxd_pipe[SYNC_STAGES-1:0], uart_rxd};
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      uart_txd <= txd_n;
      if (overrun_set)       rx_overrun <= 1'b1;
      else if (clear_errors) rx_overrun <= 1'b0;
      if (framing_set)       rx_framing_error <= 1'b1;
      else if (clear_errors) rx_framing_error <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    rx_shreg <= rx_shreg_n;
    tx_shreg <= tx_shreg_n;
  end
endmodule
